// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the MULT/MULTU/DIV/DIVU sequencer.
package muldiv_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_MULT  = 2'b00;
  localparam op_t OP_MULTU = 2'b01;
  localparam op_t OP_DIV   = 2'b10;
  localparam op_t OP_DIVU  = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Widest operand the negate helper supports; callers zero-extend and truncate.
  localparam int MD_MAX_W = 64;

  function automatic logic [MD_MAX_W-1:0] md_neg(input logic [MD_MAX_W-1:0] v);
    return ~v + 1'b1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a shared (WIDTH+1)-bit adder.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] partial,
  input  logic             lsb,
  input  logic             msb,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_partial,
  output logic             q_bit
);

  logic [WIDTH:0] lhs;
  logic [WIDTH:0] rhs;
  logic [WIDTH:0] sum;

  always_comb begin
    lhs = div_mode ? {partial, msb} : {1'b0, partial};
    if (div_mode)
      rhs = ~{1'b0, operand};
    else if (lsb)
      rhs = {1'b0, operand};
    else
      rhs = '0;
    sum = lhs + rhs + {{WIDTH{1'b0}}, div_mode};
    // Partial remainder stays below the divisor, so bit WIDTH of the difference is its sign.
    if (div_mode) begin
      q_bit        = ~sum[WIDTH];
      next_partial = q_bit ? sum[WIDTH-1:0] : lhs[WIDTH-1:0];
    end else begin
      q_bit        = sum[0];
      next_partial = sum[WIDTH:1];
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Optional MULDIV_EARLY_EXIT_EN: multiplies leave RUN once the remaining multiplier bits are zero.
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO accepted
//   PREP  | take magnitudes, record signs, detect divide by zero
//   RUN   | one multiply/divide step per cycle
//   FIX   | apply signs, load hi/lo
//   DONE  | done pulse; MTHI/MTLO and back-to-back start accepted
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2:0]         state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r, opnd, acc, q;
  logic               sgn_q, sgn_r, dz;
  logic               is_div, a_neg, b_neg, run_last;
  logic [WIDTH-1:0]   a_mag, b_mag, step_hi, res_hi, res_lo;
  logic               step_bit;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return WIDTH'(md_neg(MD_MAX_W'(v)));
  endfunction

  assign is_div = op_r[1];
  assign a_neg  = ~op_r[0] & a_r[WIDTH-1];
  assign b_neg  = ~op_r[0] & b_r[WIDTH-1];
  assign a_mag  = a_neg ? neg_w(a_r) : a_r;
  assign b_mag  = b_neg ? neg_w(b_r) : b_r;
  assign busy   = (state == ST_PREP) || (state == ST_RUN) || (state == ST_FIX);
  assign done   = (state == ST_DONE);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode     (is_div),
    .partial      (acc),
    .lsb          (q[0]),
    .msb          (q[WIDTH-1]),
    .operand      (opnd),
    .next_partial (step_hi),
    .q_bit        (step_bit)
  );

`ifdef MULDIV_EARLY_EXIT_EN
  logic [WIDTH-1:0] mrem;
  // cnt holds the steps skipped; each skipped step is a plain right shift.
  assign prod     = {acc, q} >> cnt;
  assign run_last = (cnt == CW'(1)) || (!is_div && (mrem[WIDTH-1:1] == '0));
`else
  assign prod     = {acc, q};
  assign run_last = (cnt == CW'(1));
`endif

  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (dz) begin
        res_hi = a_r;
        res_lo = '1;
      end else begin
        res_hi = sgn_r ? neg_w(acc) : acc;
        res_lo = sgn_q ? neg_w(q) : q;
      end
    end else if (sgn_q) begin
      res_lo = neg_w(prod[WIDTH-1:0]);
      res_hi = (prod[WIDTH-1:0] == '0) ? neg_w(prod[2*WIDTH-1:WIDTH]) : ~prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_r  <= '0;
      a_r   <= '0;
      b_r   <= '0;
      opnd  <= '0;
      acc   <= '0;
      q     <= '0;
      sgn_q <= 1'b0;
      sgn_r <= 1'b0;
      dz    <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef MULDIV_EARLY_EXIT_EN
      mrem  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (wr_hi) hi <= wr_data;
          if (wr_lo) lo <= wr_data;
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            op_r  <= op;
            state <= ST_PREP;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_PREP: begin
          acc   <= '0;
          q     <= is_div ? a_mag : b_mag;
          opnd  <= is_div ? b_mag : a_mag;
          sgn_q <= a_neg ^ b_neg;
          sgn_r <= a_neg;
          dz    <= is_div && (b_r == '0);
          cnt   <= CW'(WIDTH);
          state <= ST_RUN;
`ifdef MULDIV_EARLY_EXIT_EN
          mrem  <= b_mag;
          if (!is_div && (b_mag == '0)) state <= ST_FIX;
`endif
        end
        ST_RUN: begin
          acc <= step_hi;
          q   <= is_div ? {q[WIDTH-2:0], step_bit} : {step_bit, q[WIDTH-1:1]};
          cnt <= cnt - 1'b1;
`ifdef MULDIV_EARLY_EXIT_EN
          mrem <= mrem >> 1;
`endif
          if (run_last) state <= ST_FIX;
        end
        ST_FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed, table-driven bench for muldiv_seq (default build, fixed WIDTH+3 latency).
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 3;

  logic         clk = 1'b0;
  logic         rst, start, wr_hi, wr_lo, busy, done;
  logic [1:0]   op;
  logic [W-1:0] a, b, wr_data, hi, lo;

  int checks = 0;
  int failures = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string n, input logic [1:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el);
    vec_t v;
    v.name = n; v.op = o; v.a = av; v.b = bv; v.exp_hi = eh; v.exp_lo = el;
    vecs.push_back(v);
  endtask

  // Called at a negedge; start is sampled at the next rising edge (edge 0).
  task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles to the done pulse; optionally strobes wr_hi in cycle wr_cycle.
  task automatic wait_done(input int wr_cycle, output int lat, output logic [31:0] hi_mid,
                           output logic busy_ok);
    lat = 0; hi_mid = hi; busy_ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == wr_cycle + 1) begin
        wr_hi  = 1'b0;
        hi_mid = hi;
      end
      if (c == wr_cycle) begin
        wr_hi = 1'b1; wr_data = 32'h0000_1234;
      end
      if (done) begin
        if (busy) busy_ok = 1'b0;
        lat = c;
        break;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  initial begin
    int          lat, ndone;
    logic [31:0] hm;
    logic        bok;

    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;

    add_vec("multu_45x3",    OP_MULTU, 32'd45,        32'd3,         32'h0000_0000, 32'd135);
    add_vec("mult_m7x99",    OP_MULT,  32'hFFFF_FFF9, 32'd99,        32'hFFFF_FFFF, 32'hFFFF_FD4B);
    add_vec("divu_99_77",    OP_DIVU,  32'd99,        32'd77,        32'd22,        32'd1);
    add_vec("div_m7_2",      OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    add_vec("div_ovf",       OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    add_vec("divu_45_0",     OP_DIVU,  32'd45,        32'd0,         32'd45,        32'hFFFF_FFFF);
    add_vec("div_m5_0",      OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);
    add_vec("div_7_m2",      OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    add_vec("div_m7_m2",     OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3);
    add_vec("divu_max_10",   OP_DIVU,  32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999);
    add_vec("divu_0_5",      OP_DIVU,  32'd0,         32'd5,         32'd0,         32'd0);
    add_vec("mult_min_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    add_vec("multu_max_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    add_vec("mult_12345_m1", OP_MULT,  32'd12345,     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_CFC7);
    add_vec("mult_0_m5",     OP_MULT,  32'd0,         32'hFFFF_FFFB, 32'd0,         32'd0);
    add_vec("multu_2p16sq",  OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0);

    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // First vector issues from IDLE, the rest back-to-back from DONE.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(0, lat, hm, bok);
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(LAT));
      chk({vecs[i].name, "_busy"}, 32'(bok), 32'd1);
      chk({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      chk({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
    end

    @(negedge clk);
    chk("idle_after_done_busy", 32'(busy), 32'd0);
    chk("idle_after_done_done", 32'(done), 32'd0);

    wr_hi = 1'b1; wr_data = 32'h0000_CAFE;
    @(negedge clk);
    wr_hi = 1'b0;
    chk("mthi_idle", hi, 32'h0000_CAFE);
    wr_lo = 1'b1; wr_data = 32'h0000_BEEF;
    @(negedge clk);
    wr_lo = 1'b0;
    chk("mtlo_idle", lo, 32'h0000_BEEF);
    chk("mtlo_idle_hi_kept", hi, 32'h0000_CAFE);

    issue(OP_MULT, 32'd3, 32'd5);
    wait_done(10, lat, hm, bok);
    chk("mthi_busy_ignored", hm, 32'h0000_CAFE);
    chk("mthi_busy_lat", 32'(lat), 32'(LAT));
    chk("mthi_busy_hi", hi, 32'd0);
    chk("mthi_busy_lo", lo, 32'd15);

    @(negedge clk);
    wr_lo = 1'b1; wr_data = 32'h0000_AAAA;
    issue(OP_MULTU, 32'd2, 32'd3);
    wr_lo = 1'b0;
    chk("mtlo_with_start_lo", lo, 32'h0000_AAAA);
    chk("mtlo_with_start_busy", 32'(busy), 32'd1);
    wait_done(0, lat, hm, bok);
    chk("mtlo_with_start_lat", 32'(lat), 32'(LAT));
    chk("mtlo_with_start_res", lo, 32'd6);

    @(negedge clk);
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, lat, hm, bok);
    chk("start_busy_lat", 32'(lat), 32'(LAT - 6));
    chk("start_busy_hi", hi, 32'd2);
    chk("start_busy_lo", lo, 32'd14);
    @(negedge clk);
    chk("start_busy_no_requeue", 32'(busy), 32'd0);

    issue(OP_DIV, 32'd100, 32'd7);
    repeat (20) @(negedge clk);
    chk("mid_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("rst_mid_no_done", 32'(ndone), 32'd0);

    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(0, lat, hm, bok);
    chk("after_rst_lat", 32'(lat), 32'(LAT));
    chk("after_rst_hi", hi, 32'd2);
    chk("after_rst_lo", lo, 32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
